target_array_ctrl: RTL and testbench

TARGET_ARRAY_CTRL -- requirements
Module: target_array_ctrl

---
 rtl/target_array_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_target_array_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_array_ctrl.sv
// Reaction-game controller: lights one random target per round, debounces the
// phototransistor returns and keeps BCD score/round counts.
module target_array_ctrl #(
  parameter int NUM_TARGETS     = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int WINDOW_CYCLES   = 100000000,
  parameter int GAP_CYCLES      = 25000000,
  parameter int ROUNDS          = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_TARGETS-1:0] pt_in,
  output logic [NUM_TARGETS-1:0] led_out,
  output logic [7:0]             score_bcd,
  output logic [7:0]             round_bcd,
  output logic                   hit_pulse,
  output logic                   miss_pulse,
  output logic                   game_active
);

  // state  | meaning
  // IDLE   | waiting for a start edge after reset
  // SELECT | pick the next target index, clear the window timer
  // LIT    | one LED on, waiting for its debounced hit or the window to expire
  // HIT    | scored hit: pulse, bump score and round
  // MISS   | window expired: pulse, bump round
  // GAP    | all LEDs off between rounds
  // DONE   | game over, counts held until a start edge
  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_LIT, S_HIT, S_MISS, S_GAP, S_DONE
  } state_t;

  localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       ROUNDS_BCD = {4'(ROUNDS / 10), 4'(ROUNDS % 10)};
  localparam logic [15:0]      LFSR_SEED  = 16'hACE1;

  state_t state_q, state_d;

  logic [NUM_TARGETS-1:0] sync1_q, sync1_d;
  logic [NUM_TARGETS-1:0] sync2_q, sync2_d;
  logic [NUM_TARGETS-1:0] db_q, db_d;
  logic [DB_W-1:0]        db_cnt_q [NUM_TARGETS];
  logic [DB_W-1:0]        db_cnt_d [NUM_TARGETS];

  logic                   start_s_q, start_s_d;
  logic                   start_p_q, start_p_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [GAP_W-1:0]       gap_q, gap_d;

  logic [7:0]             score_q, score_d;
  logic [7:0]             round_q, round_d;
  logic [NUM_TARGETS-1:0] led_q, led_d;
  logic                   hit_q, hit_d;
  logic                   miss_q, miss_d;
  logic                   active_q, active_d;

  logic                   start_edge;
  logic                   lit_hit;
  logic                   timeout;
  logic [WIN_W-1:0]       win_inc;
  logic [IDX_W-1:0]       sel;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)          r = v;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_comb begin
    sync1_d   = pt_in;
    sync2_d   = sync1_q;
    db_d      = db_q;
    start_s_d = start;
    start_p_d = start_s_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // A debounced level only flips after DEBOUNCE_CYCLES straight disagreeing cycles
    for (int i = 0; i < NUM_TARGETS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) db_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end

    start_edge = start_s_q & ~start_p_q;

    lit_hit = 1'b0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (idx_q == IDX_W'(i)) lit_hit = db_q[i];
    end

    win_inc = win_q + WIN_W'(1);
    timeout = (win_inc == WIN_LAST);

    sel = IDX_W'(lfsr_q % 16'(NUM_TARGETS));
    if (NUM_TARGETS > 1 && sel == idx_q) begin
      sel = (sel == IDX_W'(NUM_TARGETS - 1)) ? '0 : sel + IDX_W'(1);
    end

    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    gap_d   = gap_q;
    score_d = score_q;
    round_d = round_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          score_d = 8'h00;
          round_d = 8'h00;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        idx_d   = sel;
        win_d   = '0;
        state_d = S_LIT;
      end
      S_LIT: begin
        win_d = win_inc;
        // a hit on the final window cycle still counts
        if (lit_hit)      state_d = S_HIT;
        else if (timeout) state_d = S_MISS;
      end
      S_HIT: begin
        score_d = bcd_inc(score_q);
        round_d = bcd_inc(round_q);
        gap_d   = GAP_LOAD;
        state_d = S_GAP;
      end
      S_MISS: begin
        round_d = bcd_inc(round_q);
        gap_d   = GAP_LOAD;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == '0) state_d = (round_q == ROUNDS_BCD) ? S_DONE : S_SELECT;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it
    led_d = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      led_d[i] = (state_d == S_LIT) && (idx_d == IDX_W'(i));
    end
    hit_d    = (state_d == S_HIT);
    miss_d   = (state_d == S_MISS);
    active_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_cnt_q  <= '{default: '0};
      start_s_q <= 1'b0;
      start_p_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      idx_q     <= '0;
      win_q     <= '0;
      gap_q     <= '0;
      score_q   <= 8'h00;
      round_q   <= 8'h00;
      led_q     <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_cnt_q  <= db_cnt_d;
      start_s_q <= start_s_d;
      start_p_q <= start_p_d;
      lfsr_q    <= lfsr_d;
      idx_q     <= idx_d;
      win_q     <= win_d;
      gap_q     <= gap_d;
      score_q   <= score_d;
      round_q   <= round_d;
      led_q     <= led_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      active_q  <= active_d;
    end
  end

  assign led_out     = led_q;
  assign score_bcd   = score_q;
  assign round_bcd   = round_q;
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;
  assign game_active = active_q;

endmodule

// File: tb/tb_target_array_ctrl.sv
// Directed bench for target_array_ctrl: small-parameter game scenarios plus a
// 99-round instance for BCD saturation and restart.
module tb_target_array_ctrl;

  localparam int NT = 4;

  logic          clk, rst;
  logic          start, start99;
  logic [NT-1:0] pt, pt99;
  logic [NT-1:0] led, led99;
  logic [7:0]    score, rnd, score99, rnd99;
  logic          hitp, missp, act, hit99, miss99, act99;

  target_array_ctrl #(.NUM_TARGETS(NT), .DEBOUNCE_CYCLES(4), .WINDOW_CYCLES(20),
                      .GAP_CYCLES(5), .ROUNDS(3)) dut (
    .clock(clk), .reset(rst), .start(start), .pt_in(pt), .led_out(led),
    .score_bcd(score), .round_bcd(rnd), .hit_pulse(hitp), .miss_pulse(missp),
    .game_active(act));

  target_array_ctrl #(.NUM_TARGETS(NT), .DEBOUNCE_CYCLES(4), .WINDOW_CYCLES(20),
                      .GAP_CYCLES(5), .ROUNDS(99)) dut99 (
    .clock(clk), .reset(rst), .start(start99), .pt_in(pt99), .led_out(led99),
    .score_bcd(score99), .round_bcd(rnd99), .hit_pulse(hit99), .miss_pulse(miss99),
    .game_active(act99));

  always #5 clk = ~clk;

  typedef enum int {M_HOLD, M_PULSE3, M_PULSE4, M_UNLIT, M_TMO, M_LATE} mode_t;
  typedef struct {
    mode_t      mode;
    bit         exp_hit;
    logic [7:0] exp_score;
    logic [7:0] exp_round;
    int         exp_lat;
  } vec_t;

  int checks, errors;
  int cyc;
  int hit_cnt, miss_cnt, hit99_cnt, miss99_cnt, mon_viol, lit_viol;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hitp)  hit_cnt  <= hit_cnt + 1;
    if (missp) miss_cnt <= miss_cnt + 1;
    if (hit99)  hit99_cnt  <= hit99_cnt + 1;
    if (miss99) miss99_cnt <= miss99_cnt + 1;
    if ($countones(led) > 1 || $countones(led99) > 1) mon_viol <= mon_viol + 1;
    else if (((hitp || missp) && led != '0) || ((hit99 || miss99) && led99 != '0))
      mon_viol <= mon_viol + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // t counts negedges since LIT was first seen; pt driven here is sampled at edge t+1
  function automatic logic [NT-1:0] drive(input mode_t m, input int t, input logic [NT-1:0] lit);
    case (m)
      M_HOLD:   return lit;
      M_PULSE3: return (t < 3) ? lit : '0;
      M_PULSE4: return (t < 4) ? lit : '0;
      M_UNLIT:  return ~lit;
      M_TMO:    return (t >= 12) ? lit : '0;
      M_LATE:   return (t >= 13) ? lit : '0;
      default:  return '0;
    endcase
  endfunction

  task automatic play_round(input mode_t m, output bit got_hit, output bit got_miss,
                            output int lat, output logic [NT-1:0] lit);
    int n, t;
    bit done;
    got_hit = 0; got_miss = 0; lat = -1; lit = '0;
    n = 0;
    while (led == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("lit_seen", (led != '0), 1);
    if (led == '0) return;
    lit  = led;
    t    = 0;
    done = 0;
    pt   = drive(m, 0, lit);
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
      if (m == M_UNLIT) start = (t >= 5 && t < 7);
      if (hitp || missp) begin
        done = 1; got_hit = hitp; got_miss = missp; lat = t;
      end else begin
        if (led != lit) lit_viol++;
        pt = drive(m, t, lit);
      end
    end
    pt    = '0;
    start = 1'b0;
    chk("pulse_seen", done, 1);
  endtask

  vec_t          tbl [9];
  int            miss_t [3];
  int            n, lat, h0, m0, hits99;
  bit            gh, gm;
  logic [NT-1:0] lit, prev_lit;

  initial begin
    tbl[0] = '{M_HOLD,   1'b1, 8'h01, 8'h01, 7};
    tbl[1] = '{M_PULSE3, 1'b0, 8'h01, 8'h02, 19};
    tbl[2] = '{M_UNLIT,  1'b0, 8'h01, 8'h03, 19};
    tbl[3] = '{M_TMO,    1'b1, 8'h01, 8'h01, 19};
    tbl[4] = '{M_LATE,   1'b0, 8'h01, 8'h02, 19};
    tbl[5] = '{M_PULSE4, 1'b1, 8'h02, 8'h03, 7};
    tbl[6] = '{M_HOLD,   1'b1, 8'h01, 8'h01, 7};
    tbl[7] = '{M_HOLD,   1'b1, 8'h02, 8'h02, 7};
    tbl[8] = '{M_HOLD,   1'b1, 8'h03, 8'h03, 7};

    clk = 0; rst = 1; start = 0; start99 = 0; pt = '0; pt99 = '0;
    checks = 0; errors = 0; cyc = 0; prev_lit = '0; lit_viol = 0; hits99 = 0;
    hit_cnt = 0; miss_cnt = 0; hit99_cnt = 0; miss99_cnt = 0; mon_viol = 0;

    repeat (3) @(negedge clk);
    chk("rst_led", led, 0);
    chk("rst_score", score, 8'h00);
    chk("rst_round", rnd, 8'h00);
    chk("rst_hit", hitp, 0);
    chk("rst_miss", missp, 0);
    chk("rst_active", act, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("idle_active", act, 0);

    // all-miss game: three window expiries 26 cycles apart
    do_start();
    chk("a_active", act, 1);
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!missp && !hitp && n < 80) begin
        @(negedge clk);
        n++;
      end
      chk("a_miss", missp, 1);
      chk("a_nohit", hitp, 0);
      miss_t[r] = cyc;
      if (r > 0) chk("a_spacing", miss_t[r] - miss_t[r-1], 26);
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("a_score", score, 8'h00);
    chk("a_round", rnd, 8'h03);
    chk("a_done_active", act, 0);
    chk("a_done_led", led, 0);

    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0) begin
        do_start();
        chk("g_clr_score", score, 8'h00);
        chk("g_clr_round", rnd, 8'h00);
        chk("g_active", act, 1);
      end
      h0 = hit_cnt;
      m0 = miss_cnt;
      play_round(tbl[i].mode, gh, gm, lat, lit);
      chk("v_hit", gh, tbl[i].exp_hit);
      chk("v_miss", gm, !tbl[i].exp_hit);
      chk("v_latency", lat, tbl[i].exp_lat);
      chk("v_no_repeat", (lit != prev_lit), 1);
      prev_lit = lit;
      repeat (2) @(negedge clk);
      chk("v_hit_count", hit_cnt - h0, tbl[i].exp_hit ? 1 : 0);
      chk("v_miss_count", miss_cnt - m0, tbl[i].exp_hit ? 0 : 1);
      chk("v_score", score, tbl[i].exp_score);
      chk("v_round", rnd, tbl[i].exp_round);
      chk("v_gap_led", led, 0);
      if (i % 3 == 2) begin
        repeat (8) @(negedge clk);
        chk("v_done_active", act, 0);
        chk("v_done_led", led, 0);
        chk("v_done_score", score, tbl[i].exp_score);
        chk("v_done_round", rnd, tbl[i].exp_round);
      end
    end

    // reset in the middle of a lit window
    do_start();
    play_round(M_HOLD, gh, gm, lat, lit);
    repeat (2) @(negedge clk);
    chk("r_score_before", score, 8'h01);
    n = 0;
    while (led == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("r_lit_seen", (led != '0), 1);
    h0 = hit_cnt;
    m0 = miss_cnt;
    rst = 1;
    @(negedge clk);
    chk("r_led", led, 0);
    chk("r_score", score, 8'h00);
    chk("r_round", rnd, 8'h00);
    chk("r_hit", hitp, 0);
    chk("r_miss", missp, 0);
    chk("r_active", act, 0);
    rst = 0;
    repeat (40) @(negedge clk);
    chk("r_no_hit", hit_cnt - h0, 0);
    chk("r_no_miss", miss_cnt - m0, 0);
    chk("r_idle", act, 0);

    // 99 hit rounds: BCD counts reach 99, then restart clears them
    start99 = 1'b1;
    repeat (2) @(negedge clk);
    start99 = 1'b0;
    for (int r = 0; r < 99; r++) begin
      n = 0;
      while (led99 == '0 && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("x_lit_seen", (led99 != '0), 1);
      if (led99 == '0) break;
      pt99 = led99;
      n = 0;
      while (!hit99 && n < 20) begin
        @(negedge clk);
        n++;
      end
      pt99 = '0;
      chk("x_hit_seen", hit99, 1);
      if (!hit99) break;
      hits99++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("x_hits", hits99, 99);
    chk("x_hit_pulses", hit99_cnt, 99);
    chk("x_miss_pulses", miss99_cnt, 0);
    chk("x_score", score99, 8'h99);
    chk("x_round", rnd99, 8'h99);
    chk("x_done_active", act99, 0);
    start99 = 1'b1;
    repeat (2) @(negedge clk);
    start99 = 1'b0;
    chk("x_clr_score", score99, 8'h00);
    chk("x_clr_round", rnd99, 8'h00);
    chk("x_restart_active", act99, 1);

    chk("led_onehot_viol", mon_viol, 0);
    chk("led_steady_viol", lit_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
